// File: rtl/dmem_lsu_pkg.sv
// Shared RV32I load/store width codes and the data-memory FSM state type.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Replaces the DM_* state encodings that used to live in rv32_defs.vh.
  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_e;

  // Stores only have signed-width codes; loads also allow the unsigned variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane handling: store byte enables and data shift,
// load lane extract with sign/zero extension, misalign/illegal detection.
module dmem_lane_align
  import dmem_lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misalign,
  output logic        illegal
);

  logic [4:0]  shamt;
  logic [31:0] rshift;

  assign shamt    = {addr_lo, 3'b000};
  assign wdata_sh = wdata << shamt;
  assign rshift   = rword >> shamt;

  // Decode access width into enables/alignment, and extend the selected load lane.
  always_comb begin
    be        = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    illegal   = !f3_legal(we, funct3);
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01: begin
        be       = 4'b0011 << addr_lo;
        misalign = addr_lo[0];
      end
      2'b10: begin
        be       = '1;
        misalign = (addr_lo != 2'b00);
      end
      default: ;
    endcase
    case (funct3)
      F3_B:    rdata_ext = {{24{rshift[7]}}, rshift[7:0]};
      F3_H:    rdata_ext = {{16{rshift[15]}}, rshift[15:0]};
      F3_W:    rdata_ext = rshift;
      F3_BU:   rdata_ext = {24'h0, rshift[7:0]};
      F3_HU:   rdata_ext = {16'h0, rshift[15:0]};
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// RV32I data memory with valid/ready request, single-pulse response,
// configurable read latency and fault reporting.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 4096,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [1:0]  LAT_M1 = 2'(READ_LATENCY - 1);

  logic [31:0]   mem [DEPTH_WORDS] = '{default: '0};

  dm_state_e     state;
  logic [1:0]    cnt;
  logic [31:0]   pend_rdata;
  logic          pend_fault;

  logic [AW-1:0] widx;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [31:0]   rdata_ext;
  logic          misalign;
  logic          illegal;
  logic          oor;
  logic          fault;
  logic          accept;
  logic          do_write;
  logic [31:0]   e0_rdata;

  assign widx     = req_addr[AW+1:2];
  assign rword    = mem[widx];
  assign oor      = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign fault    = oor || misalign || illegal;
  assign accept   = req_valid && req_ready;
  assign do_write = accept && req_we && !fault && !rst;
  assign e0_rdata = (fault || req_we) ? '0 : rdata_ext;

  dmem_lane_align u_align (
    .we        (req_we),
    .funct3    (req_funct3),
    .addr_lo   (req_addr[1:0]),
    .wdata     (req_wdata),
    .rword     (rword),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .misalign  (misalign),
    .illegal   (illegal)
  );

  // Stores commit their enabled bytes at the accepting edge; reset never clears the array.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // Request/response FSM: load data is captured at acceptance and held until the response slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DM_IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_fault  <= 1'b0;
      pend_rdata <= '0;
      pend_fault <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
      case (state)
        DM_IDLE, DM_RESP: begin
          if (accept) begin
            if (LAT_M1 == 2'd0) begin
              state     <= DM_RESP;
              req_ready <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_rdata <= e0_rdata;
              rsp_fault <= fault;
            end else begin
              state      <= DM_WAIT;
              cnt        <= LAT_M1;
              req_ready  <= 1'b0;
              pend_rdata <= e0_rdata;
              pend_fault <= fault;
            end
          end else begin
            state     <= DM_IDLE;
            req_ready <= 1'b1;
          end
        end
        DM_WAIT: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            state     <= DM_RESP;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= pend_rdata;
            rsp_fault <= pend_fault;
          end
        end
        default: begin
          state     <= DM_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: one instance at latency 1, one at latency 3.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        v1 = 1'b0, we1 = 1'b0;
  logic [2:0]  f1 = '0;
  logic [31:0] a1 = '0, wd1 = '0;
  logic        rdy1, rv1, rf1;
  logic [31:0] rd1;

  logic        v3 = 1'b0, we3 = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] a3 = '0, wd3 = '0;
  logic        rdy3, rv3, rf3;
  logic [31:0] rd3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH_WORDS(64), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
    .req_funct3(f1), .req_addr(a1), .req_wdata(wd1),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_fault(rf1)
  );

  dmem_lsu #(.DEPTH_WORDS(64), .READ_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_we(we3),
    .req_funct3(f3), .req_addr(a3), .req_wdata(wd3),
    .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_fault(rf3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on the chosen instance (1 or 3), started from idle; waits for the response.
  task automatic txn(input int inst, input logic we, input logic [2:0] fc,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rdata, output logic flt);
    int n;
    logic got;
    @(negedge clk);
    if (inst == 1) begin
      v1 = 1'b1; we1 = we; f1 = fc; a1 = addr; wd1 = wd;
    end else begin
      v3 = 1'b1; we3 = we; f3 = fc; a3 = addr; wd3 = wd;
    end
    @(posedge clk); #1;
    v1 = 1'b0; v3 = 1'b0;
    n = 0;
    got = (inst == 1) ? rv1 : rv3;
    while (!got && n < 10) begin
      @(posedge clk); #1;
      n++;
      got = (inst == 1) ? rv1 : rv3;
    end
    chk("rsp_arrives", {31'h0, got}, 32'h1);
    rdata = (inst == 1) ? rd1 : rd3;
    flt   = (inst == 1) ? rf1 : rf3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        f;
    logic        seen;

    do_reset();
    #1;
    chk("rst_ready1", {31'h0, rdy1}, 32'h1);
    chk("rst_valid1", {31'h0, rv1}, 32'h0);
    chk("rst_rdata1", rd1, 32'h0);
    chk("rst_fault1", {31'h0, rf1}, 32'h0);
    chk("rst_ready3", {31'h0, rdy3}, 32'h1);
    chk("rst_valid3", {31'h0, rv3}, 32'h0);

    // ---- latency 1 instance ----
    txn(1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, d, f);
    chk("sw_fault", {31'h0, f}, 32'h0);
    chk("sw_rdata", d, 32'h0);
    txn(1, 1'b0, 3'b010, 32'h10, 32'h0, d, f);
    chk("lw_data", d, 32'hDEADBEEF);
    chk("lw_fault", {31'h0, f}, 32'h0);

    txn(1, 1'b1, 3'b000, 32'h13, 32'h12345680, d, f);
    chk("sb_fault", {31'h0, f}, 32'h0);
    txn(1, 1'b0, 3'b000, 32'h13, 32'h0, d, f);
    chk("lb_sign", d, 32'hFFFFFF80);
    txn(1, 1'b0, 3'b100, 32'h13, 32'h0, d, f);
    chk("lbu_zero", d, 32'h00000080);
    txn(1, 1'b0, 3'b010, 32'h10, 32'h0, d, f);
    chk("lw_after_sb", d, 32'h80ADBEEF);
    txn(1, 1'b0, 3'b001, 32'h12, 32'h0, d, f);
    chk("lh_upper", d, 32'hFFFF80AD);
    txn(1, 1'b0, 3'b101, 32'h10, 32'h0, d, f);
    chk("lhu_lower", d, 32'h0000BEEF);
    txn(1, 1'b0, 3'b000, 32'h11, 32'h0, d, f);
    chk("lb_lane1", d, 32'hFFFFFFBE);

    txn(1, 1'b0, 3'b001, 32'h11, 32'h0, d, f);
    chk("lh_mis_fault", {31'h0, f}, 32'h1);
    chk("lh_mis_rdata", d, 32'h0);

    txn(1, 1'b1, 3'b010, 32'h20, 32'h11111111, d, f);
    txn(1, 1'b1, 3'b010, 32'h22, 32'hCAFEF00D, d, f);
    chk("sw_mis_fault", {31'h0, f}, 32'h1);
    txn(1, 1'b0, 3'b010, 32'h20, 32'h0, d, f);
    chk("sw_mis_nowrite", d, 32'h11111111);

    txn(1, 1'b0, 3'b011, 32'h20, 32'h0, d, f);
    chk("f3_011_fault", {31'h0, f}, 32'h1);
    chk("f3_011_rdata", d, 32'h0);
    txn(1, 1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, d, f);
    chk("st_f3_100_fault", {31'h0, f}, 32'h1);
    txn(1, 1'b0, 3'b010, 32'h20, 32'h0, d, f);
    chk("st_illegal_nowrite", d, 32'h11111111);

    txn(1, 1'b1, 3'b001, 32'h22, 32'h0000ABCD, d, f);
    chk("sh_fault", {31'h0, f}, 32'h0);
    txn(1, 1'b0, 3'b010, 32'h20, 32'h0, d, f);
    chk("lw_after_sh", d, 32'hABCD1111);

    // Range boundary: last word is legal, word index 64 faults and must not alias word 0.
    txn(1, 1'b1, 3'b010, 32'h0, 32'h0BADC0DE, d, f);
    txn(1, 1'b1, 3'b010, 32'hFC, 32'h00000077, d, f);
    chk("last_word_fault", {31'h0, f}, 32'h0);
    txn(1, 1'b0, 3'b010, 32'hFC, 32'h0, d, f);
    chk("last_word_data", d, 32'h00000077);
    txn(1, 1'b1, 3'b010, 32'h100, 32'h55555555, d, f);
    chk("oor_st_fault", {31'h0, f}, 32'h1);
    txn(1, 1'b0, 3'b010, 32'h100, 32'h0, d, f);
    chk("oor_ld_fault", {31'h0, f}, 32'h1);
    chk("oor_ld_rdata", d, 32'h0);
    txn(1, 1'b0, 3'b010, 32'h0, 32'h0, d, f);
    chk("oor_no_alias", d, 32'h0BADC0DE);
    txn(1, 1'b0, 3'b010, 32'hFC, 32'h0, d, f);
    chk("oor_no_alias_top", d, 32'h00000077);

    // Back-to-back store then load on consecutive cycles.
    @(negedge clk);
    v1 = 1'b1; we1 = 1'b1; f1 = 3'b010; a1 = 32'h30; wd1 = 32'hA5A5A5A5;
    @(posedge clk); #1;
    chk("b2b_st_valid", {31'h0, rv1}, 32'h1);
    chk("b2b_ready", {31'h0, rdy1}, 32'h1);
    we1 = 1'b0;
    @(posedge clk); #1;
    v1 = 1'b0;
    chk("b2b_ld_valid", {31'h0, rv1}, 32'h1);
    chk("b2b_ld_data", rd1, 32'hA5A5A5A5);
    @(posedge clk); #1;
    chk("pulse_end_valid", {31'h0, rv1}, 32'h0);
    chk("pulse_end_rdata", rd1, 32'h0);

    // ---- latency 3 instance ----
    txn(3, 1'b1, 3'b010, 32'h8, 32'h12345678, d, f);
    chk("l3_sw_fault", {31'h0, f}, 32'h0);

    @(negedge clk);
    v3 = 1'b1; we3 = 1'b0; f3 = 3'b010; a3 = 32'h8;
    @(posedge clk); #1;
    chk("l3_c1_ready", {31'h0, rdy3}, 32'h0);
    chk("l3_c1_valid", {31'h0, rv3}, 32'h0);
    @(posedge clk); #1;
    chk("l3_c2_ready", {31'h0, rdy3}, 32'h0);
    chk("l3_c2_valid", {31'h0, rv3}, 32'h0);
    @(posedge clk); #1;
    chk("l3_c3_valid", {31'h0, rv3}, 32'h1);
    chk("l3_c3_ready", {31'h0, rdy3}, 32'h1);
    chk("l3_c3_rdata", rd3, 32'h12345678);
    @(posedge clk); #1;
    v3 = 1'b0;
    chk("l3_c4_valid", {31'h0, rv3}, 32'h0);
    chk("l3_c4_ready", {31'h0, rdy3}, 32'h0);
    @(posedge clk); #1;
    chk("l3_c5_ready", {31'h0, rdy3}, 32'h0);
    @(posedge clk); #1;
    chk("l3_c6_valid", {31'h0, rv3}, 32'h1);
    chk("l3_c6_rdata", rd3, 32'h12345678);

    txn(3, 1'b0, 3'b001, 32'h9, 32'h0, d, f);
    chk("l3_mis_fault", {31'h0, f}, 32'h1);
    chk("l3_mis_rdata", d, 32'h0);

    // Reset in the cycle after a load is accepted drops its response.
    @(negedge clk);
    v3 = 1'b1; we3 = 1'b0; f3 = 3'b010; a3 = 32'h8;
    @(posedge clk); #1;
    v3 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_ready", {31'h0, rdy3}, 32'h1);
    seen = rv3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      seen = seen | rv3;
    end
    chk("rst_mid_no_rsp", {31'h0, seen}, 32'h0);
    txn(3, 1'b0, 3'b010, 32'h8, 32'h0, d, f);
    chk("rst_mem_survives", d, 32'h12345678);

    // A store accepted just before reset stays committed.
    @(negedge clk);
    v3 = 1'b1; we3 = 1'b1; f3 = 3'b010; a3 = 32'hC; wd3 = 32'h00009999;
    @(posedge clk); #1;
    v3 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    txn(3, 1'b0, 3'b010, 32'hC, 32'h0, d, f);
    chk("rst_store_kept", d, 32'h00009999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
